stack_arbiter: RTL and testbench
================================

// Module: stack_arbiter
// PURPOSE
//  Hardware LIFO stack shared by NREQ requesters through a round-robin arbiter.
//  Each requester issues push or pop operations with a valid/ready handshake.
//  Every accepted operation returns a one-cycle response with a status bit.
//  ok=1 on success; ok=0 on push-when-full or pop-when-empty.
//  Sits between software-visible command agents and a single stack storage array.
// PARAMETERS
//  NREQ   2   number of requesters (>=1)
//  WIDTH  32  data width of one stack entry
//  DEPTH  5   number of stack entries (>=1)
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  rst_n      in   1                  reset, asynchronous assert, active-low
//  req_valid  in   NREQ               requester i has an operation pending
//  req_op     in   NREQ               per requester: 0=push, 1=pop
//  req_data   in   NREQ*WIDTH         push data, slice i = [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ               one-hot grant; handshake when valid&ready
//  rsp_valid  out  NREQ               one-hot, 1-cycle pulse to the requester served
//  rsp_ok     out  1                  1=operation succeeded, 0=overflow/underflow
//  rsp_data   out  WIDTH              popped value; 0 for push or failed pop
//  count      out  $clog2(DEPTH+1)    current number of stored entries
//  full       out  1                  count==DEPTH
//  empty      out  1                  count==0
// BEHAVIOUR
//  Reset values:
//   - count=0, empty=1, full=0, rsp_valid=0, rsp_ok=0, rsp_data=0.
//   - Priority pointer=0. Storage contents are not cleared.
//  Arbitration:
//   - req_ready is combinational from req_valid and the priority pointer.
//   - At most one bit is set, and only for a requester with req_valid=1.
//   - Search starts at the pointer index and proceeds upward with wrap-around.
//   - After a grant to requester i, the pointer becomes (i+1)%NREQ.
//   - With no grant, the pointer holds.
//  Handshake:
//   - Requester holds valid/op/data stable until it sees ready.
//   - An operation is accepted in the cycle valid&ready=1.
//   - Exactly one operation is accepted per cycle at most; the rest wait.
//  Push accepted:
//   - If count<DEPTH: mem[count]<=data and count+1.
//   - Else: mem and count are unchanged, ok=0.
//  Pop accepted:
//   - If count>0: rsp_data<=mem[count-1] and count-1.
//   - Else: count is unchanged, ok=0, rsp_data=0.
//  Latency:
//   - rsp_valid/rsp_ok/rsp_data are registered, valid exactly 1 cycle after acceptance.
//   - Back-to-back acceptance is allowed every cycle.
//  count, full and empty update on the same edge as the response register.
//  Failed operations consume their grant and still produce a response (ok=0).
//  rsp_data is 0 whenever rsp_valid=0.
//  Reset mid-operation:
//   - Outputs drop to their reset values immediately (asynchronous).
//   - An in-flight response is discarded; the stack is logically emptied.
// TESTING
//  1. Req0 push 10, push 20, pop -> responses ok=1, ok=1, then ok=1 with rsp_data=20; count=1.
//  2. Push 1..5 -> all ok=1, full=1.
//     6th push -> ok=0, count=5.
//     Then pop -> rsp_data=5, full=0.
//  3. Pop on empty after reset -> rsp_valid[0]=1, ok=0, rsp_data=0; empty stays 1.
//  4. Both requesters hold push (req0 data 0xA, req1 data 0xB) for 4 cycles:
//     - ready sequence 01,10,01,10; count=4.
//     - Four pops return 0xB,0xA,0xB,0xA.
//  5. WIDTH=8, DEPTH=4: push 8'hA5, push 8'h5A, pop -> rsp_data=8'h5A ok=1; count=1.
//  6. Assert rst_n=0 during continuous pushes with count=3:
//     - count=0, empty=1, rsp_valid=0 in the same cycle.
//     - After release, the first pop returns ok=0.

Source files
------------

// File: rtl/stack_arbiter.sv
// stack_arbiter: LIFO stack shared by NREQ requesters through a round-robin arbiter.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    per-requester operation pending
//   req_op       per-requester opcode: 0=push, 1=pop
//   req_data     per-requester push data, slice i = [i*WIDTH +: WIDTH]
//   req_ready    one-hot combinational grant
//   rsp_valid    one-hot 1-cycle response pulse to the served requester
//   rsp_ok       1=success, 0=overflow/underflow
//   rsp_data     popped value; 0 for push, failed pop or idle
//   count        current number of stored entries
//   full, empty  count==DEPTH, count==0
module stack_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_op,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic                       rsp_ok,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic             rsp_ok_q, rsp_ok_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    int unsigned      scan_idx;
    logic             sel_op;
    logic [WIDTH-1:0] sel_data;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any             = 1'b1;
                gnt_idx             = PW'(scan_idx);
                req_ready[scan_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign sel_op   = req_op[gnt_idx];
    assign sel_data = req_data[int'(gnt_idx) * WIDTH +: WIDTH];

    // Next-state for stack occupancy and the registered response.
    always_comb begin
        count_d     = count_q;
        rsp_valid_d = '0;
        rsp_ok_d    = 1'b0;
        rsp_data_d  = '0;
        mem_we      = 1'b0;
        mem_waddr   = AW'(count_q);
        if (gnt_any) begin
            // Failed operations still consume the grant and get a response.
            rsp_valid_d = req_ready;
            if (!sel_op) begin
                if (count_q < CW'(DEPTH)) begin
                    mem_we   = 1'b1;
                    count_d  = count_q + 1'b1;
                    rsp_ok_d = 1'b1;
                end
            end else if (count_q != '0) begin
                count_d    = count_q - 1'b1;
                rsp_ok_d   = 1'b1;
                rsp_data_d = mem_q[AW'(count_q - 1'b1)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            count_q     <= '0;
            rsp_valid_q <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Storage is deliberately not reset; count_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= sel_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_ok    = rsp_ok_q;
    assign rsp_data  = rsp_data_q;
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and randomized checks of stack_arbiter against a queue-based
// reference model; a second small instance (WIDTH=8, DEPTH=4) covers the narrow configuration.
module tb_stack_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int D    = 5;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req_valid, req_op, req_ready, rsp_valid;
    logic [NREQ*W-1:0] req_data;
    logic            rsp_ok, full, empty;
    logic [W-1:0]    rsp_data;
    logic [2:0]      count;

    logic [1:0]  s_valid, s_op, s_ready, s_rsp_valid;
    logic [15:0] s_data;
    logic        s_rsp_ok, s_full, s_empty;
    logic [7:0]  s_rsp_data;
    logic [2:0]  s_count;

    stack_arbiter #(.NREQ(NREQ), .WIDTH(W), .DEPTH(D)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ok    (rsp_ok),
        .rsp_data  (rsp_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    stack_arbiter #(.NREQ(2), .WIDTH(8), .DEPTH(4)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (s_valid),
        .req_op    (s_op),
        .req_data  (s_data),
        .req_ready (s_ready),
        .rsp_valid (s_rsp_valid),
        .rsp_ok    (s_rsp_ok),
        .rsp_data  (s_rsp_data),
        .count     (s_count),
        .full      (s_full),
        .empty     (s_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: stack contents and round-robin pointer.
    logic [W-1:0] stk[$];
    int           ptr;
    int           last_g;
    logic [1:0]   last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs must already be driven (after a negedge). Checks grant, advances the model,
    // then checks the registered response after the edge.
    task automatic step();
        int         g;
        logic [1:0] exp_rdy, ev;
        logic       eok;
        logic [W-1:0] ed;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
        end
        exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        last_rdy = req_ready;
        ev = 2'b00; eok = 1'b0; ed = '0;
        if (g >= 0) begin
            ev  = 2'b01 << g;
            ptr = (g + 1) % NREQ;
            if (!req_op[g]) begin
                if (stk.size() < D) begin
                    stk.push_back(req_data[g*W +: W]);
                    eok = 1'b1;
                end
            end else if (stk.size() > 0) begin
                ed  = stk.pop_back();
                eok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("rsp_ok", 64'(rsp_ok), 64'(eok));
        chk("rsp_data", 64'(rsp_data), 64'(ed));
        chk("count", 64'(count), 64'(stk.size()));
        chk("full", 64'(full), 64'(stk.size() == D));
        chk("empty", 64'(empty), 64'(stk.size() == 0));
        last_g = g;
    endtask

    task automatic op1(input int r, input logic pop, input logic [W-1:0] d);
        req_valid = '0; req_op = '0; req_data = '0;
        req_valid[r] = 1'b1;
        req_op[r]    = pop;
        req_data[r*W +: W] = d;
        step();
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic do_reset();
        req_valid = '0; req_op = '0; req_data = '0;
        s_valid = '0; s_op = '0; s_data = '0;
        rst_n = 1'b0;
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_ok", 64'(rsp_ok), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stk.delete();
        ptr = 0;
    endtask

    task automatic sop(input string tag, input logic pop, input logic [7:0] d,
                       input logic eok, input logic [7:0] ed);
        s_valid = 2'b01;
        s_op    = {1'b0, pop};
        s_data  = {8'h00, d};
        #1;
        chk({tag, "_ready"}, 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 64'(s_rsp_valid), 64'd1);
        chk({tag, "_ok"}, 64'(s_rsp_ok), 64'(eok));
        chk({tag, "_data"}, 64'(s_rsp_data), 64'(ed));
        @(negedge clk);
        s_valid = '0;
    endtask

    logic [NREQ-1:0] pv, pop_r;
    logic [W-1:0]    pd [NREQ];
    logic [1:0]      exp_seq [4];
    logic [W-1:0]    exp_pop [4];

    initial begin
        rst_n = 1'b0;
        ptr = 0; last_g = -1; last_rdy = '0;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        exp_pop[0] = 32'hB; exp_pop[1] = 32'hA; exp_pop[2] = 32'hB; exp_pop[3] = 32'hA;

        // Pop on empty after reset.
        do_reset();
        op1(0, 1'b1, '0);
        chk("t3_ok", 64'(rsp_ok), 64'd0);
        chk("t3_empty", 64'(empty), 64'd1);

        // Push 10, push 20, pop.
        do_reset();
        op1(0, 1'b0, 32'd10);
        op1(0, 1'b0, 32'd20);
        op1(0, 1'b1, '0);
        chk("t1_pop_data", 64'(rsp_data), 64'd20);
        chk("t1_count", 64'(count), 64'd1);

        // Fill, overflow, pop.
        do_reset();
        for (int i = 1; i <= 5; i++) op1(0, 1'b0, W'(i));
        chk("t2_full", 64'(full), 64'd1);
        op1(0, 1'b0, 32'd6);
        chk("t2_ovf_ok", 64'(rsp_ok), 64'd0);
        chk("t2_ovf_count", 64'(count), 64'd5);
        op1(0, 1'b1, '0);
        chk("t2_pop_data", 64'(rsp_data), 64'd5);
        chk("t2_not_full", 64'(full), 64'd0);

        // Two requesters pushing simultaneously alternate grants.
        do_reset();
        req_valid = 2'b11; req_op = 2'b00; req_data = {32'hB, 32'hA};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_ready_seq", 64'(last_rdy), 64'(exp_seq[i]));
            @(negedge clk);
        end
        req_valid = '0;
        chk("t4_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            op1(0, 1'b1, '0);
            chk("t4_pop_data", 64'(rsp_data), 64'(exp_pop[i]));
        end

        // Reset asserted during continuous pushes with count=3.
        do_reset();
        req_valid = 2'b01; req_op = 2'b00;
        for (int i = 0; i < 3; i++) begin
            req_data = {32'h0, W'(i + 100)};
            step();
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        stk.delete();
        ptr = 0;
        op1(0, 1'b1, '0);
        chk("t6_pop_ok", 64'(rsp_ok), 64'd0);

        // Narrow configuration.
        do_reset();
        sop("t5_push1", 1'b0, 8'hA5, 1'b1, 8'h00);
        sop("t5_push2", 1'b0, 8'h5A, 1'b1, 8'h00);
        sop("t5_pop", 1'b1, 8'h00, 1'b1, 8'h5A);
        chk("t5_count", 64'(s_count), 64'd1);

        // Randomized traffic; each requester holds its op until granted.
        do_reset();
        pv = '0; pop_r = '0;
        for (int i = 0; i < NREQ; i++) pd[i] = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && ($urandom % 3) != 0) begin
                    pv[i]    = 1'b1;
                    pop_r[i] = 1'($urandom % 2);
                    pd[i]    = $urandom;
                end
            end
            req_valid = pv;
            req_op    = pop_r;
            req_data  = {pd[1], pd[0]};
            step();
            if (last_g >= 0) pv[last_g] = 1'b0;
            @(negedge clk);
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
